// File: rtl/icache_fetch_responder_pkg.sv
// Shared constants and request decode for the instruction-cache fetch responder.
// Holds the AXI burst/size encodings and the address segment map.
package icache_fetch_responder_pkg;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_WORD  = 3'd2;
    localparam logic [2:0]  UNCACHED_SEG   = 3'b101;
    localparam logic [31:0] KSEG_MASK      = 32'h1FFF_FFFF;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
    } fetch_req_t;

    // Fixed segment translation: strip the top three bits, flag the uncached window.
    function automatic fetch_req_t decode_fetch(input logic [31:0] vaddr);
        fetch_req_t r;
        r.paddr    = vaddr & KSEG_MASK;
        r.uncached = (vaddr[31:29] == UNCACHED_SEG);
        return r;
    endfunction

endpackage

// File: rtl/icache_fetch_responder_if.sv
// Fetch-stage handshake plus the read-only AXI channels of the fetch responder.
// Signal suffixes are relative to the responder; slave = responder, master = its environment.
interface icache_fetch_responder_if;

    logic        req_en_i;
    logic [31:0] req_addr_i;
    logic        flush_i;
    logic [31:0] cache_inst_o;
    logic        cache_valid_o;
    logic [31:0] uc_inst_o;
    logic        icache_stall_o;
    logic        icache_axi_stall_o;

    logic [3:0]  arid_o;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        arvalid_o;
    logic        arready_i;

    logic [31:0] rdata_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;

    modport slave (
        input  req_en_i, req_addr_i, flush_i, arready_i, rdata_i, rlast_i, rvalid_i,
        output cache_inst_o, cache_valid_o, uc_inst_o, icache_stall_o, icache_axi_stall_o,
        output arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o
    );

    modport master (
        output req_en_i, req_addr_i, flush_i, arready_i, rdata_i, rlast_i, rvalid_i,
        input  cache_inst_o, cache_valid_o, uc_inst_o, icache_stall_o, icache_axi_stall_o,
        input  arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o
    );

endinterface

// File: rtl/icache_fetch_responder_line_store.sv
// Direct-mapped line store: valid bits, tags and data words.
// Combinational read by index/offset; one data word per write, tag/valid on the last beat.
module icache_line_store
    import icache_fetch_responder_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(SETS),
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = 32 - 2 - IDX_W - OFF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic             wr_last_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic [31:0]      wr_data_i,
    input  logic [TAG_W-1:0] wr_tag_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS*LINE_WORDS];

    // Only the valid bits need reset; tags and data are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i && wr_last_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
            if (wr_last_i) begin
                tag_q[wr_idx_i] <= wr_tag_i;
            end
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/icache_fetch_responder.sv
// Instruction fetch responder: one-cycle lookup in a direct-mapped line store,
// with AXI line refill on a miss and single-beat AXI read for uncached fetches.
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int         SETS       = 64,
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input logic                      clk,
    input logic                      rst_n,
    icache_fetch_responder_if.slave  bus
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 2 - IDX_W - OFF_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_MISS_AR   = 3'd2;
    localparam logic [2:0] S_MISS_R    = 3'd3;
    localparam logic [2:0] S_MISS_DONE = 3'd4;
    localparam logic [2:0] S_UC_AR     = 3'd5;
    localparam logic [2:0] S_UC_R      = 3'd6;
    localparam logic [2:0] S_UC_DONE   = 3'd7;

    logic [2:0]       state_q, state_d;
    fetch_req_t       req_q, req_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      uc_data_q, uc_data_d;
    logic             drop_q, drop_d;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             st_valid;
    logic [TAG_W-1:0] st_tag;
    logic [31:0]      st_data;
    logic             wr_en;

    logic             in_lookup;
    logic             lookup_hit;
    logic             axi_busy;
    logic             stall;
    logic             accept;
    fetch_req_t       fetch_dec;

    assign req_off = req_q.paddr[OFF_W+1:2];
    assign req_idx = req_q.paddr[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag = req_q.paddr[31:OFF_W+IDX_W+2];

    icache_line_store #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (req_idx),
        .rd_off_i   (req_off),
        .rd_valid_o (st_valid),
        .rd_tag_o   (st_tag),
        .rd_data_o  (st_data),
        .wr_en_i    (wr_en),
        .wr_last_i  (bus.rlast_i),
        .wr_idx_i   (req_idx),
        .wr_off_i   (beat_q),
        .wr_data_i  (bus.rdata_i),
        .wr_tag_i   (req_tag)
    );

    assign in_lookup  = (state_q == S_LOOKUP);
    assign lookup_hit = in_lookup && !req_q.uncached && st_valid && (st_tag == req_tag);
    assign axi_busy   = (state_q == S_MISS_AR) || (state_q == S_MISS_R) ||
                        (state_q == S_UC_AR)   || (state_q == S_UC_R);
    // In LOOKUP anything other than a cached hit (miss or uncached) stalls fetch.
    assign stall      = (in_lookup && !lookup_hit) || axi_busy;
    assign accept     = ((state_q == S_IDLE) || in_lookup) && bus.req_en_i && !stall;
    assign fetch_dec  = decode_fetch(bus.req_addr_i);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        beat_d    = beat_q;
        word_d    = word_q;
        uc_data_d = uc_data_q;
        drop_d    = drop_q;
        wr_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOOKUP;
                    req_d   = fetch_dec;
                end
            end
            S_LOOKUP: begin
                if (req_q.uncached) begin
                    state_d = S_UC_AR;
                    drop_d  = bus.flush_i;
                end else if (!lookup_hit) begin
                    state_d = S_MISS_AR;
                    drop_d  = bus.flush_i;
                    beat_d  = '0;
                end else if (accept) begin
                    req_d = fetch_dec;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MISS_AR: begin
                if (bus.arready_i) state_d = S_MISS_R;
            end
            S_MISS_R: begin
                if (bus.rvalid_i) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == req_off) word_d = bus.rdata_i;
                    if (bus.rlast_i) begin
                        state_d = S_MISS_DONE;
                        beat_d  = '0;
                    end
                end
            end
            S_UC_AR: begin
                if (bus.arready_i) state_d = S_UC_R;
            end
            S_UC_R: begin
                if (bus.rvalid_i && bus.rlast_i) begin
                    uc_data_d = bus.rdata_i;
                    state_d   = S_UC_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
        endcase
        // The bus transaction cannot be aborted, so a flush only marks the result stale.
        if (axi_busy && bus.flush_i) drop_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            beat_q    <= '0;
            word_q    <= '0;
            uc_data_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            uc_data_q <= uc_data_d;
            drop_q    <= drop_d;
        end
    end

    logic        hit_out;
    logic        done_out;

    assign hit_out  = lookup_hit && !bus.flush_i;
    assign done_out = (state_q == S_MISS_DONE) && !drop_q && !bus.flush_i;

    assign bus.cache_valid_o      = hit_out || done_out;
    assign bus.cache_inst_o       = hit_out ? st_data : (done_out ? word_q : 32'd0);
    assign bus.uc_inst_o          = (state_q == S_UC_DONE) ? uc_data_q : 32'd0;
    assign bus.icache_stall_o     = stall;
    assign bus.icache_axi_stall_o = axi_busy;

    assign bus.arvalid_o = (state_q == S_MISS_AR) || (state_q == S_UC_AR);
    assign bus.arid_o    = AXI_ID;
    assign bus.araddr_o  = (state_q == S_MISS_AR) ? {req_q.paddr[31:OFF_W+2], {(OFF_W+2){1'b0}}} :
                           (state_q == S_UC_AR)   ? req_q.paddr : 32'd0;
    assign bus.arlen_o   = (state_q == S_MISS_AR) ? 8'(LINE_WORDS - 1) : 8'd0;
    assign bus.arsize_o  = bus.arvalid_o ? AXI_SIZE_WORD : 3'd0;
    assign bus.arburst_o = bus.arvalid_o ? AXI_BURST_INCR : 2'b00;
    assign bus.rready_o  = (state_q == S_MISS_R) || (state_q == S_UC_R);

endmodule
